// File: rtl/bresenham_responder.sv
// bresenham_responder
//   Responder side of the start-line handshake. A one-cycle req_1 pulse
//   starts a job. The responder latches the job address into rom_addr and
//   reads the line endpoints {x0, y0, x1, y1} from a synchronous ROM. It then
//   streams every Bresenham pixel of that line over a valid/ready interface.
//   ack_1 stays high for the whole job and falls when the last pixel is
//   accepted.
//
//   Optional feature macro: BRESENHAM_STATS_EN
//     When defined, the output px_count is added. It counts the pixels
//     accepted in the current job.
//
//   Ports
//     clk       : clock
//     rst       : synchronous reset, active low
//     req_1     : job request pulse (sampled only while idle)
//     ack_1     : busy / acknowledge
//     address   : job address, sampled together with req_1
//     rom_addr  : registered ROM read address
//     rom_data  : ROM word {x0, y0, x1, y1}, valid one cycle after rom_addr
//     px_valid  : pixel valid
//     px_ready  : downstream ready
//     px_x/px_y : current pixel coordinates
//     px_last   : current pixel is the line end point
//     px_count  : accepted pixel count (BRESENHAM_STATS_EN only)
module bresenham_responder #(
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_1,
    output logic                 ack_1,
    input  logic [ADDR_W-1:0]    address,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [4*COORD_W-1:0] rom_data,
    output logic                 px_valid,
    input  logic                 px_ready,
    output logic [COORD_W-1:0]   px_x,
    output logic [COORD_W-1:0]   px_y,
    output logic                 px_last
`ifdef BRESENHAM_STATS_EN
    ,
    output logic [COORD_W:0]     px_count
`endif
);

    localparam int EW = COORD_W + 2;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
`ifdef BRESENHAM_STATS_EN
    localparam logic [COORD_W:0] CNT_ONE = (COORD_W+1)'(1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        DRAW
    } state_t;

    state_t state;

    logic [COORD_W-1:0]   x1_r;
    logic [COORD_W-1:0]   y1_r;
    logic signed [EW-1:0] dx_r;
    logic signed [EW-1:0] dy_r;
    logic signed [EW-1:0] err_r;
    logic                 sx_neg;
    logic                 sy_neg;

    // ROM word fields, x0 in the MSBs
    logic [COORD_W-1:0] rx0;
    logic [COORD_W-1:0] ry0;
    logic [COORD_W-1:0] rx1;
    logic [COORD_W-1:0] ry1;

    assign rx0 = rom_data[4*COORD_W-1 -: COORD_W];
    assign ry0 = rom_data[3*COORD_W-1 -: COORD_W];
    assign rx1 = rom_data[2*COORD_W-1 -: COORD_W];
    assign ry1 = rom_data[COORD_W-1   -: COORD_W];

    // Setup terms derived from the ROM word during Load
    logic [COORD_W-1:0]   adx;
    logic [COORD_W-1:0]   ady;
    logic signed [EW-1:0] ld_dx;
    logic signed [EW-1:0] ld_dy;

    always_comb begin
        adx   = (rx1 >= rx0) ? (rx1 - rx0) : (rx0 - rx1);
        ady   = (ry1 >= ry0) ? (ry1 - ry0) : (ry0 - ry1);
        ld_dx = signed'({2'b00, adx});
        ld_dy = -signed'({2'b00, ady});
    end

    // One Bresenham step. e2 gets an extra bit so that doubling err can never
    // wrap. Both tests use the pre-step error.
    logic signed [EW:0]   e2;
    logic signed [EW:0]   dx_e;
    logic signed [EW:0]   dy_e;
    logic                 step_x;
    logic                 step_y;
    logic [COORD_W-1:0]   nx;
    logic [COORD_W-1:0]   ny;
    logic signed [EW-1:0] nerr;
    logic                 hs;

    always_comb begin
        e2     = {err_r, 1'b0};
        dx_e   = {dx_r[EW-1], dx_r};
        dy_e   = {dy_r[EW-1], dy_r};
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);
        nerr   = err_r;
        nx     = px_x;
        ny     = px_y;
        if (step_x) begin
            nerr = nerr + dy_r;
            nx   = sx_neg ? (px_x - ONE) : (px_x + ONE);
        end
        if (step_y) begin
            nerr = nerr + dx_r;
            ny   = sy_neg ? (px_y - ONE) : (px_y + ONE);
        end
    end

    assign hs = px_valid & px_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ack_1    <= 1'b0;
            rom_addr <= '0;
            px_valid <= 1'b0;
            px_last  <= 1'b0;
            px_x     <= '0;
            px_y     <= '0;
            x1_r     <= '0;
            y1_r     <= '0;
            dx_r     <= '0;
            dy_r     <= '0;
            err_r    <= '0;
            sx_neg   <= 1'b0;
            sy_neg   <= 1'b0;
`ifdef BRESENHAM_STATS_EN
            px_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_1) begin
                        rom_addr <= address;
                        ack_1    <= 1'b1;
`ifdef BRESENHAM_STATS_EN
                        px_count <= '0;
`endif
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    state <= LOAD;
                end

                LOAD: begin
                    x1_r     <= rx1;
                    y1_r     <= ry1;
                    dx_r     <= ld_dx;
                    dy_r     <= ld_dy;
                    err_r    <= ld_dx + ld_dy;
                    sx_neg   <= !(rx0 < rx1);
                    sy_neg   <= !(ry0 < ry1);
                    px_x     <= rx0;
                    px_y     <= ry0;
                    px_last  <= (rx0 == rx1) && (ry0 == ry1);
                    px_valid <= 1'b1;
                    state    <= DRAW;
                end

                DRAW: begin
                    if (hs) begin
`ifdef BRESENHAM_STATS_EN
                        px_count <= px_count + CNT_ONE;
`endif
                        if (px_last) begin
                            ack_1    <= 1'b0;
                            px_valid <= 1'b0;
                            px_last  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            px_x    <= nx;
                            px_y    <= ny;
                            err_r   <= nerr;
                            // px_last is registered, so it is evaluated on the
                            // pixel being stepped to.
                            px_last <= (nx == x1_r) && (ny == y1_r);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
